// File: rtl/hazard_unit.sv
// hazard_unit: interlock, bypass-select and flush control for a 5-stage
// MIPS-style pipeline (F, D, E, M, W).
// The multi-cycle MDU interlock (busy counter, mdu_busy, MDU stall term) is
// built only when the macro HAZARD_MDU_EN is defined; otherwise mdu_busy is
// tied low and mdu_start_D / mdu_read_D are ignored.

module hazard_unit #(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 8,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] rs_D,
    input  logic [REG_AW-1:0] rt_D,
    input  logic              rs_useD,
    input  logic              rt_useD,
    input  logic              rs_useE,
    input  logic              rt_useE,
    input  logic [REG_AW-1:0] rs_E,
    input  logic [REG_AW-1:0] rt_E,
    input  logic              wr_E,
    input  logic              wr_M,
    input  logic              wr_W,
    input  logic [REG_AW-1:0] waddr_E,
    input  logic [REG_AW-1:0] waddr_M,
    input  logic [REG_AW-1:0] waddr_W,
    input  logic [1:0]        wsrc_E,
    input  logic [1:0]        wsrc_M,
    input  logic              redirect_D,
    input  logic              mdu_start_D,
    input  logic              mdu_read_D,
    output logic              PCWr,
    output logic              pipeRegWr_F,
    output logic              pipeRegWr_D,
    output logic              pipeRegWr_E,
    output logic              pipeRegWr_M,
    output logic              pipeRegWr_W,
    output logic              flush_F,
    output logic              flush_D,
    output logic              flush_E,
    output logic              flush_M,
    output logic              flush_W,
    output logic              stall_D,
    output logic [2:0]        rs_D_Bp_Sel,
    output logic [2:0]        rt_D_Bp_Sel,
    output logic [2:0]        rs_E_Bp_Sel,
    output logic [2:0]        rt_E_Bp_Sel,
    output logic              mdu_busy
);

    // Write-data source encodings.
    localparam logic [1:0] WSRC_ALU  = 2'd0;
    localparam logic [1:0] WSRC_DM   = 2'd1;
    localparam logic [1:0] WSRC_LINK = 2'd2;

    // Bypass mux selects.
    localparam logic [2:0] BP_RF     = 3'd0;
    localparam logic [2:0] BP_E_LINK = 3'd1;
    localparam logic [2:0] BP_M_ALU  = 3'd2;
    localparam logic [2:0] BP_M_LINK = 3'd3;
    localparam logic [2:0] BP_W      = 3'd4;

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MDU_LAT);

    // A producer matches only if it really writes, is not a bubble, and is not $0.
    function automatic logic hit(input logic [REG_AW-1:0] src, input logic wr,
                                 input logic fl, input logic [REG_AW-1:0] dst);
        return wr && !fl && (dst != '0) && (dst == src);
    endfunction

    // D-stage select: youngest producer wins; a non-forwardable E/M match
    // (stall case) blocks older producers so stale data is never chosen.
    function automatic logic [2:0] sel_d(input logic use_op, input logic he,
                                         input logic hm, input logic hw,
                                         input logic [1:0] ws_e, input logic [1:0] ws_m);
        logic [2:0] s;
        s = BP_RF;
        if (use_op) begin
            if (he) begin
                if (ws_e == WSRC_LINK) s = BP_E_LINK;
            end else if (hm) begin
                if (ws_m == WSRC_ALU)       s = BP_M_ALU;
                else if (ws_m == WSRC_LINK) s = BP_M_LINK;
            end else if (hw) begin
                s = BP_W;
            end
        end
        return s;
    endfunction

    // E-stage select: M has priority over W.
    function automatic logic [2:0] sel_e(input logic use_op, input logic hm,
                                         input logic hw, input logic [1:0] ws_m);
        logic [2:0] s;
        s = BP_RF;
        if (use_op) begin
            if (hm) begin
                if (ws_m == WSRC_ALU)       s = BP_M_ALU;
                else if (ws_m == WSRC_LINK) s = BP_M_LINK;
            end else if (hw) begin
                s = BP_W;
            end
        end
        return s;
    endfunction

    logic flush_f_q, flush_d_q, flush_e_q, flush_m_q, flush_w_q;
    logic flush_f_d, flush_d_d, flush_e_d, flush_m_d, flush_w_d;

    logic rs_d_hit_e, rs_d_hit_m, rs_d_hit_w;
    logic rt_d_hit_e, rt_d_hit_m, rt_d_hit_w;
    logic rs_e_hit_m, rs_e_hit_w, rt_e_hit_m, rt_e_hit_w;
    logic stall_raw, mdu_stall;

    assign rs_d_hit_e = hit(rs_D, wr_E, flush_e_q, waddr_E);
    assign rs_d_hit_m = hit(rs_D, wr_M, flush_m_q, waddr_M);
    assign rs_d_hit_w = hit(rs_D, wr_W, flush_w_q, waddr_W);
    assign rt_d_hit_e = hit(rt_D, wr_E, flush_e_q, waddr_E);
    assign rt_d_hit_m = hit(rt_D, wr_M, flush_m_q, waddr_M);
    assign rt_d_hit_w = hit(rt_D, wr_W, flush_w_q, waddr_W);
    assign rs_e_hit_m = hit(rs_E, wr_M, flush_m_q, waddr_M);
    assign rs_e_hit_w = hit(rs_E, wr_W, flush_w_q, waddr_W);
    assign rt_e_hit_m = hit(rt_E, wr_M, flush_m_q, waddr_M);
    assign rt_e_hit_w = hit(rt_E, wr_W, flush_w_q, waddr_W);

`ifdef HAZARD_MDU_EN
    logic [CNT_W-1:0] mdu_cnt_q, mdu_cnt_d;

    assign mdu_busy  = (mdu_cnt_q != '0);
    assign mdu_stall = mdu_busy && (mdu_start_D || mdu_read_D);

    // MDU countdown: load on an accepted start, count down to zero, hold there.
    always_comb begin
        // NOTE: default assignment first so no path leaves mdu_cnt_d unassigned (no latch).
        mdu_cnt_d = mdu_cnt_q;
        if (mdu_start_D && !flush_D) mdu_cnt_d = LAT_C;
        else if (mdu_busy)           mdu_cnt_d = mdu_cnt_q - CNT_W'(1);
    end

    // MDU counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) mdu_cnt_q <= '0;
        else        mdu_cnt_q <= mdu_cnt_d;
    end
`else
    logic unused_mdu;
    assign mdu_busy   = 1'b0;
    assign mdu_stall  = 1'b0;
    assign unused_mdu = ^{mdu_start_D, mdu_read_D, LAT_C};
`endif

    // Interlock: operands that cannot be bypassed in time, plus MDU busy.
    always_comb begin
        stall_raw = 1'b0;
        if (((rs_useD && rs_d_hit_e) || (rt_useD && rt_d_hit_e)) &&
            (wsrc_E == WSRC_ALU || wsrc_E == WSRC_DM)) stall_raw = 1'b1;
        if (((rs_useD && rs_d_hit_m) || (rt_useD && rt_d_hit_m)) &&
            (wsrc_M == WSRC_DM)) stall_raw = 1'b1;
        if (((rs_useE && rs_d_hit_e) || (rt_useE && rt_d_hit_e)) &&
            (wsrc_E == WSRC_DM)) stall_raw = 1'b1;
        if (mdu_stall) stall_raw = 1'b1;
    end

    // A stalled D slot is turned into a bubble travelling down into E.
    assign stall_D     = !flush_d_q && stall_raw;
    assign flush_F     = flush_f_q;
    assign flush_D     = flush_d_q || stall_D;
    assign flush_E     = flush_e_q;
    assign flush_M     = flush_m_q;
    assign flush_W     = flush_w_q;

    assign PCWr        = !stall_D;
    assign pipeRegWr_F = !stall_D;
    assign pipeRegWr_D = !stall_D;
    assign pipeRegWr_E = 1'b1;
    assign pipeRegWr_M = 1'b1;
    assign pipeRegWr_W = 1'b1;

    assign rs_D_Bp_Sel = sel_d(rs_useD, rs_d_hit_e, rs_d_hit_m, rs_d_hit_w, wsrc_E, wsrc_M);
    assign rt_D_Bp_Sel = sel_d(rt_useD, rt_d_hit_e, rt_d_hit_m, rt_d_hit_w, wsrc_E, wsrc_M);
    assign rs_E_Bp_Sel = sel_e(rs_useE, rs_e_hit_m, rs_e_hit_w, wsrc_M);
    assign rt_E_Bp_Sel = sel_e(rt_useE, rt_e_hit_m, rt_e_hit_w, wsrc_M);

    // Flush chain next state: bubbles shift one stage per cycle; redirects
    // from a slot that is already a bubble are ignored.
    always_comb begin
        flush_f_d = 1'b0;
        flush_d_d = flush_f_q || (redirect_D && !flush_D);
        flush_e_d = flush_D;
        flush_m_d = flush_e_q;
        flush_w_d = flush_m_q;
    end

    // Flush registers; reset fills the whole pipe with bubbles.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every stage samples its neighbour's pre-edge value.
        if (!rst_n) begin
            flush_f_q <= 1'b1;
            flush_d_q <= 1'b1;
            flush_e_q <= 1'b1;
            flush_m_q <= 1'b1;
            flush_w_q <= 1'b1;
        end else begin
            flush_f_q <= flush_f_d;
            flush_d_q <= flush_d_d;
            flush_e_q <= flush_e_d;
            flush_m_q <= flush_m_d;
            flush_w_q <= flush_w_d;
        end
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, register address width.
REQ-002 The block SHALL have parameter MDU_LAT, default 8, multi-cycle MDU latency in cycles (1..15).
REQ-003 The block SHALL have parameter CNT_W, default 4, MDU counter width; MDU_LAT SHALL be at most 2^CNT_W-1.
REQ-004 The block SHALL have one clock and a reset that is synchronous and active-low, named clk and rst_n.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 rs_D, rt_D  in  REG_AW each  source register addresses of the D-stage instruction.
REQ-008 rs_useD, rt_useD  in  1 each  operand consumed in D (branch compare, jr).
REQ-009 rs_useE, rt_useE  in  1 each  operand consumed in E (ALU, address, store data).
REQ-010 rs_E, rt_E  in  REG_AW each  source register addresses of the E-stage instruction.
REQ-011 wr_E, wr_M, wr_W  in  1 each  stage instruction writes the GPR.
REQ-012 waddr_E, waddr_M, waddr_W  in  REG_AW each  GPR destination per stage.
REQ-013 wsrc_E, wsrc_M  in  2 each  write-data source: 0 ALU, 1 DM, 2 link (PC+8).
REQ-014 redirect_D  in  1  taken branch or jump resolved in D.
REQ-015 mdu_start_D, mdu_read_D  in  1 each  D instruction starts MDU op / reads HI-LO.
REQ-016 PCWr, pipeRegWr_F, pipeRegWr_D, pipeRegWr_E, pipeRegWr_M, pipeRegWr_W  out  1 each  write enables.
REQ-017 flush_F, flush_D, flush_E, flush_M, flush_W  out  1 each  stage holds a bubble; controls masked.
REQ-018 stall_D  out  1  D-stage interlock active.
REQ-019 rs_D_Bp_Sel, rt_D_Bp_Sel, rs_E_Bp_Sel, rt_E_Bp_Sel  out  3 each  bypass mux selects.
REQ-020 mdu_busy  out  1  MDU counter nonzero.

Function
REQ-021 Address 0 SHALL never match for stall or bypass; a match requires the write enable of the source stage and not its flush.
REQ-022 stall_D SHALL assert combinationally when D is not flushed by flush_D_r and any holds: useD operand matches E with wsrc_E in {0,1}; useD operand matches M with wsrc_M=1; useE operand matches E with wsrc_E=1; mdu_busy and (mdu_start_D or mdu_read_D).
REQ-023 While stall_D: PCWr, pipeRegWr_F and pipeRegWr_D SHALL be 0; pipeRegWr_E/M/W SHALL be 1.
REQ-024 flush_D SHALL equal flush_D_r OR stall_D; flush_F/E/M/W SHALL equal their registers.
REQ-025 Flush chain SHALL shift every cycle: flush_D_r<=flush_F OR (redirect_D AND NOT flush_D), flush_E_r<=flush_D, flush_M_r<=flush_E, flush_W_r<=flush_M, flush_F_r<=0.
REQ-026 redirect_D SHALL be ignored while flush_D is 1.
REQ-027 D bypass select (priority E, M, W, then 0): E link match ->1; M ALU match ->2; M link match ->3; W match ->4; else 0 (register file).
REQ-028 E bypass select (priority M, W): M ALU match ->2; M link match ->3; W match ->4; else 0; selects SHALL be 0 when the matching use bit is 0.
REQ-029 MDU counter SHALL load MDU_LAT on the cycle mdu_start_D is accepted (not flush_D), decrement by 1 each cycle while nonzero, never wrap below 0.
REQ-030 mdu_busy SHALL equal (counter != 0); a start is first allowed in the cycle after counter reaches 0.

Reset
REQ-031 On rst_n=0 at a clock edge, all flush registers SHALL become 1 and the MDU counter 0.
REQ-032 During and immediately after reset, all Bp_Sel outputs SHALL be 0, stall_D 0, mdu_busy 0, and PCWr/pipeRegWr_* 1.
REQ-033 Reset mid-MDU-operation SHALL clear the counter in that cycle; all flushes clear one stage per cycle afterwards.

Configuration
REQ-034 With macro HAZARD_MDU_EN defined, the MDU counter, mdu_busy and the MDU stall term SHALL be present as specified.
REQ-035 Without HAZARD_MDU_EN, the counter SHALL be absent, mdu_busy SHALL be tied 0 and mdu_start_D/mdu_read_D SHALL be ignored.

Verification
REQ-036 Load-use: E lw wr_E=1 waddr_E=8 wsrc_E=1, D rs_D=8 rs_useE=1 -> stall_D=1 one cycle, PCWr=0, next cycle flush_E=1, rs_E_Bp_Sel=4 after M->W.
REQ-037 Branch on ALU result: M addu waddr_M=9 wsrc_M=0, D beq rt_D=9 rt_useD=1 -> rt_D_Bp_Sel=2, stall_D=0.
REQ-038 jal in E (waddr_E=31, wsrc_E=2), D jr rs_D=31 -> rs_D_Bp_Sel=1, no stall; same with waddr 0 target -> select 0.
REQ-039 Redirect: redirect_D=1 with flush_D=0 -> flush_D=1 next cycle, flush_E=1 the cycle after; redirect_D=1 during stall -> no squash.
REQ-040 MDU (HAZARD_MDU_EN, MDU_LAT=8): start at cycle 0 -> mdu_busy cycles 1-8; mdu_read_D at cycle 3 stalls until cycle 9.
REQ-041 Reset: rst_n=0 for 2 cycles during MDU op -> counter 0, all flush=1; release -> flush_F=0 first, flush_W=0 four cycles later.
